// File: rtl/padder_if.sv
// Word and block handshake between the host/permutation side (master) and the
// padder sequencer (slave).
interface padder_if;
  logic [31:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         f_ack;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready
  );
endinterface

// File: rtl/padder_ctrl.sv
// Packs 32-bit message words into 576-bit Keccak rate blocks and applies
// pad10*1 (0x01 after the last byte, 0x80 in the final byte of the block).
module padder_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  padder_if.slave    bus,
  output logic [1:0] state_dbg,
  output logic [4:0] cnt_dbg
);
  // Handshake: a word is consumed on a rising edge where in_ready=1,
  // buffer_full=0 and the sequencer is in ABSORB; otherwise the host must hold
  // it. out_ready mirrors buffer_full, and f_ack is honoured only while full.
  typedef enum logic [1:0] {ABSORB = 2'd0, PAD = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        full;
  logic [31:0] last_word;

  assign full            = (cnt == 5'd18);
  assign bus.buffer_full = full;
  assign bus.out_ready   = full;
  assign state_dbg       = state;
  assign cnt_dbg         = cnt;

  // Last-word padder; folds in the closing 0x80 when it lands in slot 17.
  always_comb begin
    last_word = 32'h0100_0000;
    case (bus.byte_num)
      2'd0: last_word = 32'h0100_0000;
      2'd1: last_word = {bus.in[31:24], 24'h01_0000};
      2'd2: last_word = {bus.in[31:16], 16'h0100};
      2'd3: last_word = {bus.in[31:8], 8'h01};
      default: last_word = 32'h0100_0000;
    endcase
    if (cnt == 5'd17) last_word = last_word | 32'h0000_0080;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ABSORB;
      cnt     <= 5'd0;
      bus.out <= '0;
    end else if (full) begin
      if (bus.f_ack) cnt <= 5'd0;
    end else begin
      case (state)
        ABSORB: begin
          if (bus.in_ready) begin
            cnt <= cnt + 5'd1;
            if (bus.is_last) begin
              bus.out <= {bus.out[543:0], last_word};
              state   <= (cnt == 5'd17) ? DONE : PAD;
            end else begin
              bus.out <= {bus.out[543:0], bus.in};
            end
          end
        end
        PAD: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd17) begin
            bus.out <= {bus.out[543:0], 32'h0000_0080};
            state   <= DONE;
          end else begin
            bus.out <= {bus.out[543:0], 32'h0000_0000};
          end
        end
        DONE:    state <= DONE;
        default: state <= ABSORB;
      endcase
    end
  end
endmodule

// File: tb/tb_padder_ctrl.sv
// Directed bench for padder_ctrl: expected blocks go into a queue, a monitor
// pops one each time a block becomes valid.
module tb_padder_ctrl;
  logic       clk;
  logic       reset_n;
  logic [1:0] state_dbg;
  logic [4:0] cnt_dbg;

  padder_if bus ();

  padder_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg),
    .cnt_dbg   (cnt_dbg)
  );

  localparam logic [1:0] S_ABSORB = 2'd0;
  localparam logic [1:0] S_PAD    = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  int vectors = 0;
  int miscompares = 0;
  logic [575:0] exp_q[$];
  logic seen;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [575:0] shl(input logic [575:0] b, input logic [31:0] w);
    return {b[543:0], w};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    bus.in_ready = 1'b0; bus.is_last = 1'b0; bus.byte_num = 2'd0; bus.f_ack = 1'b0; bus.in = '0;
    #1;
    chk("reset_out", bus.out, '0);
    chk("reset_full", {575'd0, bus.buffer_full}, '0);
    chk("reset_out_ready", {575'd0, bus.out_ready}, '0);
    chk("reset_state", {574'd0, state_dbg}, {574'd0, S_ABSORB});
    chk("reset_cnt", {571'd0, cnt_dbg}, '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // driver: present one word and hold it until it is consumed
  task automatic drive_word(input logic [31:0] d, input logic last, input logic [1:0] bn);
    int t = 0;
    @(negedge clk);
    bus.in = d; bus.in_ready = 1'b1; bus.is_last = last; bus.byte_num = bn;
    while (bus.buffer_full && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      vectors++; miscompares++;
      $display("FAIL drive_timeout: word %0h still held after %0d cycles", d, t);
    end
    @(posedge clk);
    #1;
    bus.in_ready = 1'b0; bus.is_last = 1'b0;
  endtask

  task automatic ack_block();
    int t = 0;
    @(negedge clk);
    while (!bus.buffer_full && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      vectors++; miscompares++;
      $display("FAIL ack_timeout: buffer_full never rose within %0d cycles", t);
    end
    bus.f_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.f_ack = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset_n || !bus.out_ready) begin
      seen <= 1'b0;
    end else if (!seen) begin
      seen <= 1'b1;
      chk("out_ready_eq_full", {575'd0, bus.out_ready}, {575'd0, bus.buffer_full});
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_block: got %0h expected none", bus.out);
      end else begin
        chk("block", bus.out, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [575:0] e, e1;
    int n;
    seen = 1'b0;
    do_reset();

    // empty message
    e1 = shl('0, 32'h0100_0000);
    for (int i = 0; i < 16; i++) e1 = shl(e1, 32'h0);
    e1 = shl(e1, 32'h0000_0080);
    exp_q.push_back(e1);
    drive_word(32'hFFFF_FFFF, 1'b1, 2'd0);
    n = 0;
    while (!bus.buffer_full && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("empty_latency", 576'(n), 576'd17);
    chk("empty_state_done", {574'd0, state_dbg}, {574'd0, S_DONE});
    ack_block();
    bus.in = 32'h5555_5555; bus.in_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("done_cnt", {571'd0, cnt_dbg}, '0);
      chk("done_full", {575'd0, bus.buffer_full}, '0);
    end
    chk("done_out_kept", bus.out, e1);
    bus.in_ready = 1'b0;

    // 17 words then 3-byte last word in slot 17
    do_reset();
    e = '0;
    for (int i = 0; i < 17; i++) e = shl(e, 32'h1000_0000 + 32'(i));
    e = shl(e, 32'h1122_3381);
    exp_q.push_back(e);
    for (int i = 0; i < 17; i++) drive_word(32'h1000_0000 + 32'(i), 1'b0, 2'd0);
    drive_word(32'h1122_3344, 1'b1, 2'd3);
    chk("slot17_full_next", {575'd0, bus.buffer_full}, {575'd0, 1'b1});
    chk("slot17_state_done", {574'd0, state_dbg}, {574'd0, S_DONE});
    ack_block();

    // back-pressure with a held word
    do_reset();
    e = '0;
    for (int i = 0; i < 18; i++) e = shl(e, 32'hA000_0000 + 32'(i));
    exp_q.push_back(e);
    for (int i = 0; i < 18; i++) drive_word(32'hA000_0000 + 32'(i), 1'b0, 2'd0);
    @(negedge clk);
    bus.in = 32'hDEAD_BEEF; bus.in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_cnt", {571'd0, cnt_dbg}, 576'd18);
      chk("held_out", bus.out, e);
    end
    bus.f_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.f_ack = 1'b0;
    chk("ack_full_low", {575'd0, bus.buffer_full}, '0);
    chk("ack_cnt0", {571'd0, cnt_dbg}, '0);
    @(posedge clk);
    #1;
    bus.in_ready = 1'b0;
    chk("held_accept_cnt", {571'd0, cnt_dbg}, 576'd1);
    chk("held_accept_word", {544'd0, bus.out[31:0]}, {544'd0, 32'hDEAD_BEEF});
    e = shl('0, 32'hDEAD_BEEF);
    e = shl(e, 32'h0100_0000);
    for (int i = 0; i < 15; i++) e = shl(e, 32'h0);
    e = shl(e, 32'h0000_0080);
    exp_q.push_back(e);
    drive_word(32'h0, 1'b1, 2'd0);
    ack_block();

    // multi-block message
    do_reset();
    e = '0;
    for (int i = 0; i < 18; i++) e = shl(e, 32'hC000_0000 + 32'(i));
    exp_q.push_back(e);
    e = shl('0, 32'hC000_0012);
    e = shl(e, 32'hC000_0013);
    e = shl(e, 32'hAA01_0000);
    for (int i = 0; i < 14; i++) e = shl(e, 32'h0);
    e = shl(e, 32'h0000_0080);
    exp_q.push_back(e);
    for (int i = 0; i < 18; i++) drive_word(32'hC000_0000 + 32'(i), 1'b0, 2'd0);
    ack_block();
    drive_word(32'hC000_0012, 1'b0, 2'd0);
    drive_word(32'hC000_0013, 1'b0, 2'd0);
    drive_word(32'hAABB_CCDD, 1'b1, 2'd1);
    ack_block();

    // reset while padding
    do_reset();
    for (int i = 0; i < 3; i++) drive_word(32'hE000_0000 + 32'(i), 1'b0, 2'd0);
    drive_word(32'hE0E1_E2E3, 1'b1, 2'd2);
    n = 0;
    while (cnt_dbg != 5'd9 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midpad_state", {574'd0, state_dbg}, {574'd0, S_PAD});
    do_reset();
    drive_word(32'h1234_5678, 1'b0, 2'd0);
    chk("post_reset_cnt", {571'd0, cnt_dbg}, 576'd1);
    chk("post_reset_out", bus.out, {544'd0, 32'h1234_5678});

    repeat (3) @(negedge clk);
    chk("queue_drained", 576'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/padder_ctrl.md
# padder_ctrl

Sequencer that packs a 32-bit message word stream into 576-bit Keccak rate blocks for the low-throughput core and applies pad10*1 at end of message. It drives the per-word last-word padder (0x01 inserted after `byte_num` valid bytes) and appends zero words and the final 0x80 byte itself. It sits between the host word interface and the permutation engine, with back-pressure from the permutation via `buffer_full`/`f_ack`.

## Interface
- No parameters; block width fixed at 18 words × 32 bits = 576 bits.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  async active-low reset.
- `in`  in  32  message word; first message byte in `in[31:24]`.
- `in_ready`  in  1  `in` valid this cycle.
- `is_last`  in  1  with `in_ready`: this word ends the message.
- `byte_num`  in  2  valid bytes in the last word (0..3); only meaningful with `is_last`.
- `buffer_full`  out  1  block complete; input stalled.
- `out`  out  576  assembled block; word 0 in `out[575:544]`, word 17 in `out[31:0]`.
- `out_ready`  out  1  equals `buffer_full`; block valid for permutation.
- `f_ack`  in  1  permutation has absorbed `out`; frees the buffer.

## Operation
- State: `ABSORB`, `PAD`, `DONE`; word counter `cnt` 0..18; `buffer_full = (cnt == 18)`.
- Shift: each accepted/generated word `w` gives `out <= {out[543:0], w}`, `cnt <= cnt + 1`.
- `ABSORB`, `in_ready & !buffer_full`:
  - `!is_last`: `w = in`.
  - `is_last`: `w = pad1(in, byte_num)` (byte_num 0: 0x01000000; 1: {in[31:24],0x010000}; 2: {in[31:16],0x0100}; 3: {in[31:8],0x01}); go `PAD`.
  - If `cnt == 17` and `is_last`: `w` additionally ORed with 0x00000080; go `DONE`.
- A 4-byte final message word is sent with `is_last=0`, then an `is_last=1, byte_num=0` word (`in` ignored).
- `PAD`, `!buffer_full`: one word per cycle; `w = 0` for `cnt < 17`; `w = 0x00000080` at `cnt == 17`, then go `DONE`.
- `PAD` with `buffer_full`: hold until `f_ack`, then continue padding in the next block (`cnt` 0..17).
- `DONE`: no input accepted; `in_ready` ignored.
- `f_ack & buffer_full`: `cnt <= 0`; `out` retains contents. `f_ack` while not full is ignored.
- `in_ready` while full or in `PAD`/`DONE`: no accept, word not consumed; the host holds it.

## Timing
- Reset (async, `reset_n` low): `out = 0`, `cnt = 0`, `buffer_full = 0`, `out_ready = 0`, state `ABSORB`. Reset mid-block or mid-`PAD` discards everything.
- Accept at edge E: `out` updated after E. The 18th word at edge E gives `buffer_full = 1` after E.
- `f_ack` at edge E while full: `buffer_full = 0` after E. A held word can be accepted at E+1, giving zero bubble.
- Last word accepted at slot k (<17) at edge E: `PAD` fills slots k+1..17 on edges E+1..E+17-k, and `buffer_full` rises after E+17-k.
- Throughput: 1 word/cycle when not full.

## Test plan
- Empty message: `is_last=1, byte_num=0` at `cnt=0` -> block = 0x01000000, 16×0, 0x00000080; `buffer_full` rises 17 edges after accept; state `DONE`.
- 17 words then `is_last, byte_num=3, in=0x11223344` -> word 17 = 0x11223381; `buffer_full` the next cycle; no `PAD` cycles; `DONE`.
- Back-pressure: 18 words fill, then word 0xDEADBEEF held with `in_ready` -> not consumed while full; `f_ack` -> accepted next cycle as word 0 of block 2, `cnt=1`.
- Multi-block: 20 words then `is_last, byte_num=1, in=0xAABBCCDD` -> block 2 = data, data, 0xAA010000, 14×0, 0x00000080.
- Reset mid-`PAD` (pull `reset_n` low at `cnt=9`) -> `out=0`, `buffer_full=0`, `ABSORB`; next word is accepted at `cnt=0`.
- After the final `f_ack` in `DONE`: keep `in_ready=1` for 30 cycles -> `cnt` stays 0, `out` unchanged, `buffer_full=0`.
